// File: rtl/cmp_iter.sv
// Multi-cycle chunked magnitude/equality comparator with valid/ready on both sides.
// Optional CMP_MINMAX_EN adds minmax_out (selected original operand).
module cmp_iter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [2:0]       function_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] minmax_out
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             less_q;
    logic             neg_q;
    logic [WIDTH-1:0] sign_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_diff;
    logic             res_next;
    logic             scan_end;

`ifdef CMP_MINMAX_EN
    logic             sign_q;
    logic [WIDTH-1:0] sign_lat;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] b_orig;
`endif

    assign in_ready  = (state == S_IDLE) && !reset;
    assign out_valid = (state == S_DONE);

    // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
    always_comb begin
        sign_in = '0;
        sign_in[WIDTH-1] = function_select[1];
    end

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // A differing chunk decides is_less; reaching chunk 0 with no difference means equal.
    always_comb begin
        chunk_diff = (a_chunk != b_chunk);
        scan_end   = chunk_diff || (idx == '0);
        res_next   = neg_q ^ (less_q ? (chunk_diff && (a_chunk < b_chunk)) : !chunk_diff);
    end

`ifdef CMP_MINMAX_EN
    always_comb begin
        sign_lat = '0;
        sign_lat[WIDTH-1] = sign_q;
        a_orig = a_q ^ sign_lat;
        b_orig = b_q ^ sign_lat;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= IDX_W'(NCHUNK - 1);
            result <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            less_q <= 1'b0;
            neg_q  <= 1'b0;
`ifdef CMP_MINMAX_EN
            sign_q     <= 1'b0;
            minmax_out <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q    <= input_a ^ sign_in;
                        b_q    <= input_b ^ sign_in;
                        less_q <= function_select[2];
                        neg_q  <= function_select[0];
`ifdef CMP_MINMAX_EN
                        sign_q <= function_select[1];
`endif
                        idx    <= IDX_W'(NCHUNK - 1);
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_end) begin
                        result <= res_next;
`ifdef CMP_MINMAX_EN
                        minmax_out <= res_next ? a_orig : b_orig;
`endif
                        state  <= S_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed table-driven bench for cmp_iter (WIDTH=64, CHUNK=8), plus
// backpressure and mid-scan reset sequences; minmax checks when CMP_MINMAX_EN is set.
module tb_cmp_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] input_a;
    logic [63:0] input_b;
    logic [2:0]  function_select;
    logic        out_valid;
    logic        out_ready;
    logic        result;
`ifdef CMP_MINMAX_EN
    logic [63:0] minmax_out;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmp_iter #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .input_a(input_a),
        .input_b(input_b),
        .function_select(function_select),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
`ifdef CMP_MINMAX_EN
        ,
        .minmax_out(minmax_out)
`endif
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  fs;
        logic        exp_res;
        int          exp_lat;
        logic [63:0] exp_mm;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one request, measure cycles to out_valid, then leave it pending in DONE.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] fs,
                         output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        input_a = a;
        input_b = b;
        function_select = fs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: out_valid %0b expected 1", out_valid);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{64'd1, 64'd2, 3'b100, 1'b1, 8, 64'd1};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b110, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b100, 1'b0, 1, 64'd0};
        vecs[3]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b000, 1'b1, 8, 64'h0123_4567_89AB_CDEF};
        vecs[4]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b001, 1'b0, 8, 64'h0123_4567_89AB_CDEF};
        vecs[5]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b101, 1'b1, 8, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{64'h0000_0100_0000_0000, 64'd0, 3'b101, 1'b1, 3, 64'h0000_0100_0000_0000};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110, 1'b1, 1, 64'h8000_0000_0000_0000};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 1'b0, 1, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{64'd5, 64'd3, 3'b100, 1'b0, 8, 64'd3};
        vecs[10] = '{64'd5, 64'd3, 3'b101, 1'b1, 8, 64'd5};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        input_a = '0;
        input_b = '0;
        function_select = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
`ifdef CMP_MINMAX_EN
        check("reset_minmax", minmax_out, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].fs, lat);
            check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].exp_res));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
`ifdef CMP_MINMAX_EN
            check($sformatf("v%0d_minmax", i), minmax_out, vecs[i].exp_mm);
`endif
            drain();
        end

        // Backpressure: result must hold and a new request must be refused.
        issue(64'd1, 64'd2, 3'b100, lat);
        check("bp_latency", 64'(lat), 64'd8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            input_a = 64'd9;
            input_b = 64'd9;
            function_select = 3'b001;
            in_valid = (c % 2 == 0);
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(result), 64'd1);
        end
        in_valid = 1'b0;
        drain();
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_no_stale_accept", 64'(out_valid), 64'd0);
        end

        // Reset three cycles into a full-length scan aborts it without output.
        issue_partial();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_idle_in_ready", 64'(in_ready), 64'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("rst_no_spurious", 64'(out_valid), 64'd0);
        end
        issue(64'd7, 64'd7, 3'b000, lat);
        check("post_rst_result", 64'(result), 64'd1);
        check("post_rst_latency", 64'(lat), 64'd8);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    task automatic issue_partial();
        @(negedge clk);
        input_a = 64'h0123_4567_89AB_CDEF;
        input_b = 64'h0123_4567_89AB_CDEF;
        function_select = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        check("rst_result_clr", 64'(result), 64'd0);
    endtask

endmodule
